zigbee_cordic_vec_pipe: RTL and testbench
=========================================

// Module: zigbee_cordic_vec_pipe
// PURPOSE
//  Parametrised vectoring CORDIC: phase and raw magnitude of (ibb,qbb), plus wrapped phase
//  difference between consecutive samples (frequency discriminator for O-QPSK demod).
//  Configurable pipeline register spacing; valid/ready backpressure. Sits between baseband I/Q
//  and the chip/symbol decision logic.
// PARAMETERS
//  IQ_SIZE     5  signed I/Q input width
//  W_SIZE      6  angle width; full turn = 2^W_SIZE (range 4..16)
//  NUM_STAGES  4  micro-rotation stages (1..12)
//  REG_EVERY   2  pipeline register after every REG_EVERY stages and after the last (>=1)
// PORTS
//  clk     in   1               clock, rising edge
//  reset_n in   1               reset, synchronous, active-low
//  ibb     in   IQ_SIZE         signed in-phase sample
//  qbb     in   IQ_SIZE         signed quadrature sample
//  iValid  in   1               input sample valid
//  iReady  out  1               block accepts input this cycle
//  wout    out  W_SIZE          signed phase, 2^(W_SIZE-1) = 180 deg
//  mag     out  IQ_SIZE+2       unsigned magnitude x CORDIC gain (~1.65), not normalised
//  wdelta  out  W_SIZE          wout minus previous output wout, mod 2^W_SIZE
//  oValid  out  1               outputs valid
//  oReady  in   1               downstream accepts outputs
// BEHAVIOUR
//  Reset (reset_n low at clk edge): all pipe regs, wout, mag, wdelta, oValid = 0; prev-phase
//   register = 0 and first-flag set. Reset mid-operation discards all in-flight samples.
//  Global advance en = !oValid || oReady; iReady = en. Input accepted when iValid && en.
//   en=0: every register holds (full stall, no bubble compression, no sample loss/duplication).
//  Latency (no stall) = 1 + ceil(NUM_STAGES/REG_EVERY) cycles accept->oValid; throughput 1/clk.
//  Stage 0 (registered): sign-extend I/Q to XY = IQ_SIZE+2 bits before negation (-2^(IQ_SIZE-1)
//   must not overflow). ibb<0: x=-i, y=-q, w=2^(W_SIZE-1); else x=i, y=q, w=0.
//  Micro-rotation k (comb, arithmetic shift, floor): y>=0: x+=y>>>k, y-=x>>>k, w+=A_k;
//   else x-=y>>>k, y+=x>>>k, w-=A_k. Old x,y used on both right-hand sides. w wraps mod 2^W_SIZE.
//  A_k = round(T_k / 2^(16-W_SIZE)), T = {8192,4836,2555,1297,651,326,163,81,41,20,10,5};
//   round half toward zero on the 2^-16-turn table (W=6, N=4: A = 8,5,2,1).
//  Output reg: wout=w, mag=x (x>=0 always after stage 0), valid follows pipe.
//  wdelta = wout - prev (W_SIZE wrap). prev updates to wout on each output handshake
//   (oValid && oReady). Output sample following reset: wdelta=0, first-flag clears.
//  ibb=qbb=0: wout=0, mag=0, counts as a normal sample for wdelta.
//  oValid may only fall after a handshake; outputs stable while oValid && !oReady.
// TESTING (IQ=5, W=6, N=4, R=2, latency 3)
//  T1 (ibb,qbb)=(0,8), oReady=1 -> 3 cycles later oValid=1, wout=16, mag=13, wdelta=0 (first).
//  T2 stream (0,8),(-8,0),(8,0) -> wout 16,-32,0; mag 13,14,14; wdelta 0,16,-32 (wrap).
//  T3 ibb=-16,qbb=0 -> no overflow: wout=-32, mag within IQ_SIZE+2 range, x>0 at stage 0.
//  T4 oValid=1, oReady=0 for 5 cycles while iValid=1 -> iReady=0, outputs frozen, no sample lost
//   or duplicated after oReady returns; wdelta chain unaffected.
//  T5 reset_n low 1 cycle with 3 samples in flight -> next cycle oValid=0, outputs 0; next
//   accepted sample gives wdelta=0.
//  T6 random I/Q, N in {4,8,12}, R in {1,3}, random oReady -> match bit-exact reference model.

Source files
------------

// File: rtl/zigbee_cordic_vec_pipe.sv
// Vectoring CORDIC: phase, raw magnitude and wrapped phase step of (ibb,qbb).
// Pipeline register every REG_EVERY micro-rotations; global stall on backpressure.
module zigbee_cordic_vec_pipe #(
  parameter int IQ_SIZE    = 5,
  parameter int W_SIZE     = 6,
  parameter int NUM_STAGES = 4,
  parameter int REG_EVERY  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IQ_SIZE-1:0]   ibb,
  input  logic [IQ_SIZE-1:0]   qbb,
  input  logic                 iValid,
  output logic                 iReady,
  output logic [W_SIZE-1:0]    wout,
  output logic [IQ_SIZE+1:0]   mag,
  output logic [W_SIZE-1:0]    wdelta,
  output logic                 oValid,
  input  logic                 oReady
);

  localparam int XY = IQ_SIZE + 2;
  localparam int SH = 16 - W_SIZE;
  localparam int ATAN_T [12] = '{8192, 4836, 2555, 1297, 651, 326,
                                 163, 81, 41, 20, 10, 5};
  localparam logic [W_SIZE-1:0] HALF = {1'b1, {(W_SIZE-1){1'b0}}};

  // round half toward zero from the 2^-16 turn table
  function automatic logic [W_SIZE-1:0] atan_k(input int k);
    int r;
    r = (ATAN_T[k] + (((1 << SH) - 1) >> 1)) >> SH;
    return r[W_SIZE-1:0];
  endfunction

  logic                 en;
  logic signed [XY-1:0] ie, qe;
  logic signed [XY-1:0] s0_x, s0_y;
  logic [W_SIZE-1:0]    s0_w;
  logic                 s0_v, s0_z;
  logic [W_SIZE-1:0]    prev;
  logic                 first;
  logic [W_SIZE-1:0]    w_last;
  logic                 z_last;

  assign ie = {{2{ibb[IQ_SIZE-1]}}, ibb};
  assign qe = {{2{qbb[IQ_SIZE-1]}}, qbb};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s0_x <= '0;
      s0_y <= '0;
      s0_w <= '0;
      s0_v <= 1'b0;
      s0_z <= 1'b0;
    end else if (en) begin
      s0_v <= iValid;
      s0_z <= (ibb == '0) && (qbb == '0);
      if (ibb[IQ_SIZE-1]) begin
        s0_x <= -ie;
        s0_y <= -qe;
        s0_w <= HALF;
      end else begin
        s0_x <= ie;
        s0_y <= qe;
        s0_w <= '0;
      end
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_rot
    localparam logic [W_SIZE-1:0] AK = atan_k(k);
    logic signed [XY-1:0] xi, yi, xn, yn, xo, yo;
    logic [W_SIZE-1:0]    wi, wn, wo;
    logic                 vi, zi, vo, zo;

    if (k == 0) begin : g_src
      assign xi = s0_x;
      assign yi = s0_y;
      assign wi = s0_w;
      assign vi = s0_v;
      assign zi = s0_z;
    end else begin : g_src
      assign xi = g_rot[k-1].xo;
      assign yi = g_rot[k-1].yo;
      assign wi = g_rot[k-1].wo;
      assign vi = g_rot[k-1].vo;
      assign zi = g_rot[k-1].zo;
    end

    always_comb begin
      if (!yi[XY-1]) begin
        xn = xi + (yi >>> k);
        yn = yi - (xi >>> k);
        wn = wi + AK;
      end else begin
        xn = xi - (yi >>> k);
        yn = yi + (xi >>> k);
        wn = wi - AK;
      end
    end

    if (((k + 1) % REG_EVERY == 0) || (k == NUM_STAGES - 1)) begin : g_reg
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          xo <= '0;
          yo <= '0;
          wo <= '0;
          vo <= 1'b0;
          zo <= 1'b0;
        end else if (en) begin
          xo <= xn;
          yo <= yn;
          wo <= wn;
          vo <= vi;
          zo <= zi;
        end
      end
    end else begin : g_pass
      assign xo = xn;
      assign yo = yn;
      assign wo = wn;
      assign vo = vi;
      assign zo = zi;
    end
  end

  assign w_last = g_rot[NUM_STAGES-1].wo;
  assign z_last = g_rot[NUM_STAGES-1].zo;
  assign oValid = g_rot[NUM_STAGES-1].vo;
  assign mag    = g_rot[NUM_STAGES-1].xo;

  // an all-zero input has no defined angle; report it as zero
  assign wout   = z_last ? '0 : w_last;
  assign en     = !oValid || oReady;
  assign iReady = en;
  assign wdelta = first ? '0 : wout - prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev  <= '0;
      first <= 1'b1;
    end else if (oValid && oReady) begin
      prev  <= wout;
      first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zigbee_cordic_vec_pipe.sv
// Scoreboard bench for zigbee_cordic_vec_pipe: directed steps plus random
// streams on a default instance (N=4,R=2) and a deep instance (N=12,R=3).
module tb_zigbee_cordic_vec_pipe;

  logic       clk;
  logic       reset_n;
  logic [4:0] ibb, qbb;
  logic       i_valid;
  logic       o_ready;
  logic       rand_rdy;

  logic       a_iready, a_ovalid;
  logic [5:0] a_wout, a_wdelta;
  logic [6:0] a_mag;

  logic       b_ivalid, b_iready, b_ovalid;
  logic [5:0] b_wout, b_wdelta;
  logic [6:0] b_mag;

  int checks = 0;
  int errors = 0;

  logic [18:0] qa[$];
  logic [18:0] qb[$];
  logic [18:0] ea, eb;
  logic [5:0]  prev_a, prev_b;
  bit          first_a, first_b;

  zigbee_cordic_vec_pipe #(
    .IQ_SIZE(5), .W_SIZE(6), .NUM_STAGES(4), .REG_EVERY(2)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .ibb(ibb), .qbb(qbb),
    .iValid(i_valid), .iReady(a_iready), .wout(a_wout), .mag(a_mag),
    .wdelta(a_wdelta), .oValid(a_ovalid), .oReady(o_ready)
  );

  // deep instance only sees samples the main instance accepts
  assign b_ivalid = i_valid && a_iready;

  zigbee_cordic_vec_pipe #(
    .IQ_SIZE(5), .W_SIZE(6), .NUM_STAGES(12), .REG_EVERY(3)
  ) u_deep (
    .clk(clk), .reset_n(reset_n), .ibb(ibb), .qbb(qbb),
    .iValid(b_ivalid), .iReady(b_iready), .wout(b_wout), .mag(b_mag),
    .wdelta(b_wdelta), .oValid(b_ovalid), .oReady(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endfunction

  task automatic model(input int i, input int q, input int n,
                       output logic [5:0] w, output logic [6:0] m);
    int at [12] = '{8, 5, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    int x, y, a, xn;
    bit neg;
    if (i == 0 && q == 0) begin
      w = 6'd0;
      m = 7'd0;
    end else begin
      if (i < 0) begin x = -i; y = -q; a = 32; end
      else begin x = i; y = q; a = 0; end
      for (int k = 0; k < n; k++) begin
        neg = (y < 0);
        xn  = neg ? x - (y >>> k) : x + (y >>> k);
        y   = neg ? y + (x >>> k) : y - (x >>> k);
        a   = neg ? a - at[k] : a + at[k];
        x   = xn;
      end
      w = a[5:0];
      m = x[6:0];
    end
  endtask

  task automatic push_a(input logic [5:0] w, input logic [6:0] m);
    logic [5:0] d;
    d = first_a ? 6'd0 : w - prev_a;
    qa.push_back({w, m, d});
    prev_a  = w;
    first_a = 0;
  endtask

  task automatic push_b(input logic [5:0] w, input logic [6:0] m);
    logic [5:0] d;
    d = first_b ? 6'd0 : w - prev_b;
    qb.push_back({w, m, d});
    prev_b  = w;
    first_b = 0;
  endtask

  // dir=1 uses the given expectation for the main instance, else the model
  task automatic drive(input int i, input int q, input bit dir,
                       input logic [5:0] ew, input logic [6:0] em);
    bit done;
    logic [5:0] w;
    logic [6:0] m;
    done = 0;
    ibb = i[4:0];
    qbb = q[4:0];
    i_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (a_iready) begin
        if (dir) push_a(ew, em);
        else begin
          model(i, q, 4, w, m);
          push_a(w, m);
        end
        model(i, q, 12, w, m);
        push_b(w, m);
        chk("b_iready", b_iready, 1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    chk("drive_accept", done, 1);
  endtask

  task automatic drain();
    i_valid = 1'b0;
    for (int t = 0; t < 300 && (qa.size() != 0 || qb.size() != 0); t++)
      @(posedge clk);
    @(posedge clk);
    #1;
    chk("a_drained", qa.size(), 0);
    chk("b_drained", qb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n && a_ovalid && o_ready) begin
      chk("a_queue_nonempty", int'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        chk("a_wout", a_wout, ea[18:13]);
        chk("a_mag", a_mag, ea[12:6]);
        chk("a_wdelta", a_wdelta, ea[5:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && b_ovalid) begin
      chk("b_queue_nonempty", int'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        chk("b_wout", b_wout, eb[18:13]);
        chk("b_mag", b_mag, eb[12:6]);
        chk("b_wdelta", b_wdelta, eb[5:0]);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      o_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int cnt;
    logic [5:0] sw, sd;
    logic [6:0] sm;
    reset_n  = 1'b0;
    ibb      = '0;
    qbb      = '0;
    i_valid  = 1'b0;
    o_ready  = 1'b1;
    rand_rdy = 1'b0;
    first_a  = 1;
    first_b  = 1;
    prev_a   = '0;
    prev_b   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ovalid", a_ovalid, 0);
    chk("rst_wout", a_wout, 0);
    chk("rst_mag", a_mag, 0);
    chk("rst_wdelta", a_wdelta, 0);
    chk("rst_iready", a_iready, 1);
    chk("rst_b_ovalid", b_ovalid, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // single sample, latency
    drive(0, 8, 1, 6'd16, 7'd13);
    i_valid = 1'b0;
    cnt = 1;
    while (!a_ovalid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("t1_latency", cnt, 3);
    drain();

    // back-to-back stream with wrap, overflow corner, zero input
    drive(0, 8, 1, 6'd16, 7'd13);
    drive(-8, 0, 1, 6'd32, 7'd14);
    drive(8, 0, 1, 6'd0, 7'd14);
    drive(-16, 0, 1, 6'd32, 7'd27);
    drive(0, 0, 1, 6'd0, 7'd0);
    drive(-16, -16, 0, 6'd0, 7'd0);
    drive(15, -16, 0, 6'd0, 7'd0);
    drain();

    // backpressure: fill, then hold for five cycles
    o_ready = 1'b0;
    drive(5, 3, 0, 6'd0, 7'd0);
    drive(-3, 7, 0, 6'd0, 7'd0);
    drive(-9, -2, 0, 6'd0, 7'd0);
    ibb = 5'd4;
    qbb = 5'h1c;
    i_valid = 1'b1;
    @(negedge clk);
    sw = a_wout;
    sm = a_mag;
    sd = a_wdelta;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("t4_iready", a_iready, 0);
      chk("t4_ovalid", a_ovalid, 1);
      chk("t4_wout_hold", a_wout, sw);
      chk("t4_mag_hold", a_mag, sm);
      chk("t4_wdelta_hold", a_wdelta, sd);
    end
    @(posedge clk);
    #1;
    o_ready = 1'b1;
    drive(4, -4, 0, 6'd0, 7'd0);
    drain();

    // reset with samples in flight
    drive(7, 7, 0, 6'd0, 7'd0);
    drive(-7, 2, 0, 6'd0, 7'd0);
    drive(1, -9, 0, 6'd0, 7'd0);
    i_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    qa.delete();
    qb.delete();
    first_a = 1;
    first_b = 1;
    @(negedge clk);
    chk("t5_ovalid", a_ovalid, 0);
    chk("t5_wout", a_wout, 0);
    chk("t5_mag", a_mag, 0);
    chk("t5_wdelta", a_wdelta, 0);
    chk("t5_b_ovalid", b_ovalid, 0);
    @(posedge clk);
    #1;
    drive(8, 0, 1, 6'd0, 7'd14);
    drive(0, 8, 1, 6'd16, 7'd13);
    drain();

    // random samples with random downstream readiness
    rand_rdy = 1'b1;
    repeat (150) begin
      int ri, rq;
      ri = int'($urandom_range(0, 31)) - 16;
      rq = int'($urandom_range(0, 31)) - 16;
      drive(ri, rq, 0, 6'd0, 7'd0);
      if ($urandom_range(0, 3) == 0) begin
        i_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    i_valid = 1'b0;
    for (int t = 0; t < 400 && qa.size() != 0; t++) @(posedge clk);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    o_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
